// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding in front of the 64-bit ALU.
// Captures decoded operands/control, resolves RAW hazards from EX/MEM and MEM/WB, supports stall and flush.
module id_ex_operand_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int ZERO_REG   = 31
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic [4:0]            InRn,
    input  logic [4:0]            InRm,
    input  logic [4:0]            InRd,
    input  logic [DATA_WIDTH-1:0] InBusA,
    input  logic [DATA_WIDTH-1:0] InBusB,
    input  logic [DATA_WIDTH-1:0] InImm,
    input  logic                  InALUSrc,
    input  logic [3:0]            InALUCtrl,
    input  logic                  InRegWrite,
    input  logic                  InMemRead,
    input  logic                  InMemWrite,
    input  logic                  ExMemRegWrite,
    input  logic [4:0]            ExMemRd,
    input  logic [DATA_WIDTH-1:0] ExMemResult,
    input  logic                  MemWbRegWrite,
    input  logic [4:0]            MemWbRd,
    input  logic [DATA_WIDTH-1:0] MemWbData,
    output logic                  Valid,
    output logic [DATA_WIDTH-1:0] BusA,
    output logic [DATA_WIDTH-1:0] BusB,
    output logic [DATA_WIDTH-1:0] StoreData,
    output logic [3:0]            ALUCtrl,
    output logic [4:0]            Rd,
    output logic                  RegWrite,
    output logic                  MemRead,
    output logic                  MemWrite
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic                  valid_reg;
    logic [4:0]            rd_reg;
    logic [DATA_WIDTH-1:0] imm_reg;
    logic                  alu_src_reg;
    logic [3:0]            alu_ctrl_reg;
    logic                  reg_write_reg;
    logic                  mem_read_reg;
    logic                  mem_write_reg;

    logic [4:0]            in_src [2];
    logic [DATA_WIDTH-1:0] in_bus [2];
    logic [DATA_WIDTH-1:0] fwd    [2];

    assign in_src[0] = InRn;
    assign in_src[1] = InRm;
    assign in_bus[0] = InBusA;
    assign in_bus[1] = InBusB;

    // Operand 0 is A (from Rn), operand 1 is the B source / store data (from Rm).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic [4:0]            src_reg;
            logic [DATA_WIDTH-1:0] raw_reg;
            logic [DATA_WIDTH-1:0] raw_next;
            logic                  wb_hit_in;
            logic                  wb_hit_held;
            logic                  ex_hit_held;

            assign wb_hit_in   = MemWbRegWrite && (MemWbRd == in_src[gi]);
            assign wb_hit_held = MemWbRegWrite && (MemWbRd == src_reg) && (src_reg != ZR);
            assign ex_hit_held = ExMemRegWrite && (ExMemRd == src_reg) && (src_reg != ZR);

            // Stall refresh keeps a writeback result that would otherwise retire unseen.
            always_comb begin
                raw_next = raw_reg;
                if (Reset || Flush) begin
                    raw_next = '0;
                end else if (Stall) begin
                    if (wb_hit_held)
                        raw_next = MemWbData;
                end else if (in_src[gi] == ZR) begin
                    raw_next = '0;
                end else if (wb_hit_in) begin
                    raw_next = MemWbData;
                end else begin
                    raw_next = in_bus[gi];
                end
            end

            always_ff @(posedge Clk) begin
                raw_reg <= raw_next;
                if (Reset || Flush)
                    src_reg <= '0;
                else if (!Stall)
                    src_reg <= in_src[gi];
            end

            // Youngest producer (EX/MEM) wins over MEM/WB.
            assign fwd[gi] = ex_hit_held ? ExMemResult :
                             wb_hit_held ? MemWbData   : raw_reg;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            valid_reg     <= 1'b0;
            rd_reg        <= '0;
            imm_reg       <= '0;
            alu_src_reg   <= 1'b0;
            alu_ctrl_reg  <= 4'b0000;
            reg_write_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else if (!Stall) begin
            valid_reg     <= InValid;
            rd_reg        <= InRd;
            imm_reg       <= InImm;
            alu_src_reg   <= InALUSrc;
            alu_ctrl_reg  <= InALUCtrl;
            reg_write_reg <= InRegWrite;
            mem_read_reg  <= InMemRead;
            mem_write_reg <= InMemWrite;
        end
    end

    assign Valid     = valid_reg;
    assign BusA      = fwd[0];
    assign StoreData = fwd[1];
    assign BusB      = alu_src_reg ? imm_reg : fwd[1];
    assign ALUCtrl   = alu_ctrl_reg;
    assign Rd        = rd_reg;
    assign RegWrite  = reg_write_reg;
    assign MemRead   = mem_read_reg;
    assign MemWrite  = mem_write_reg;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed, table-driven bench for id_ex_operand_stage plus hand sequences for stall/flush/reset corners.
module tb_id_ex_operand_stage;
    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, InValid;
    logic [4:0]  InRn, InRm, InRd;
    logic [63:0] InBusA, InBusB, InImm;
    logic        InALUSrc;
    logic [3:0]  InALUCtrl;
    logic        InRegWrite, InMemRead, InMemWrite;
    logic        ExMemRegWrite;
    logic [4:0]  ExMemRd;
    logic [63:0] ExMemResult;
    logic        MemWbRegWrite;
    logic [4:0]  MemWbRd;
    logic [63:0] MemWbData;
    logic        Valid;
    logic [63:0] BusA, BusB, StoreData;
    logic [3:0]  ALUCtrl;
    logic [4:0]  Rd;
    logic        RegWrite, MemRead, MemWrite;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    id_ex_operand_stage #(.DATA_WIDTH(64), .ZERO_REG(31)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .InRn(InRn), .InRm(InRm), .InRd(InRd), .InBusA(InBusA), .InBusB(InBusB),
        .InImm(InImm), .InALUSrc(InALUSrc), .InALUCtrl(InALUCtrl),
        .InRegWrite(InRegWrite), .InMemRead(InMemRead), .InMemWrite(InMemWrite),
        .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
        .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
        .Valid(Valid), .BusA(BusA), .BusB(BusB), .StoreData(StoreData),
        .ALUCtrl(ALUCtrl), .Rd(Rd), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite)
    );

    typedef struct {
        logic [4:0]  rn, rm, rd;
        logic [63:0] bus_a, bus_b, imm;
        logic        alu_src;
        logic [3:0]  ctrl;
        logic        valid, rw, mr, mw;
        logic        ex_we;
        logic [4:0]  ex_rd;
        logic [63:0] ex_res;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [63:0] wb_data;
        logic [63:0] exp_a, exp_b, exp_s;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Reset = 0; Stall = 0; Flush = 0; InValid = 0;
        InRn = 0; InRm = 0; InRd = 0; InBusA = 0; InBusB = 0; InImm = 0;
        InALUSrc = 0; InALUCtrl = 0; InRegWrite = 0; InMemRead = 0; InMemWrite = 0;
        ExMemRegWrite = 0; ExMemRd = 0; ExMemResult = 0;
        MemWbRegWrite = 0; MemWbRd = 0; MemWbData = 0;
    endtask

    task automatic capture(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                           input logic [63:0] a, input logic [63:0] b, input logic rw, input logic mw);
        InValid = 1; InRn = rn; InRm = rm; InRd = rd; InBusA = a; InBusB = b;
        InImm = 64'h0; InALUSrc = 0; InALUCtrl = 4'b0010;
        InRegWrite = rw; InMemRead = 0; InMemWrite = mw;
    endtask

    initial begin
        // rn rm rd, busA busB imm, src ctrl, valid rw mr mw, ex we/rd/res, wb we/rd/data, exp A B S
        vecs[0] = '{5'd1, 5'd2, 5'd9, 64'h5, 64'h7, 64'h10, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h5, 64'h10, 64'h7};
        vecs[1] = '{5'd3, 5'd4, 5'd10, 64'h11, 64'h22, 64'h0, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB, 64'hAA, 64'h22, 64'h22};
        vecs[2] = '{5'd3, 5'd4, 5'd10, 64'h11, 64'h22, 64'h0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB, 64'hBB, 64'h22, 64'h22};
        vecs[3] = '{5'd31, 5'd31, 5'd11, 64'h55, 64'h66, 64'h0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd31, 64'h77, 1'b1, 5'd31, 64'h88, 64'h0, 64'h0, 64'h0};
        vecs[4] = '{5'd6, 5'd5, 5'd0, 64'h9, 64'h1, 64'h0, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1,
                    1'b1, 5'd5, 64'h1234, 1'b1, 5'd6, 64'h4242, 64'h4242, 64'h1234, 64'h1234};
        vecs[5] = '{5'd6, 5'd5, 5'd12, 64'h9, 64'h1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0,
                    1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 64'h0, 64'h9, 64'hFFFF_FFFF_FFFF_FFF0, 64'h55};
        vecs[6] = '{5'd2, 5'd3, 5'd13, 64'h100, 64'h200, 64'h0, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h100, 64'h200, 64'h200};

        idle_inputs();

        // Reset with nonzero inputs present
        @(negedge Clk);
        Reset = 1;
        capture(5'd7, 5'd8, 5'd9, 64'hDEAD, 64'hBEEF, 1'b1, 1'b1);
        InImm = 64'h123; InALUCtrl = 4'b0110;
        @(posedge Clk);
        @(negedge Clk);
        $display("[TB] reset: Valid=%0b RegWrite=%0b BusA=%h BusB=%h ALUCtrl=%b", Valid, RegWrite, BusA, BusB, ALUCtrl);
        check("reset_valid", 64'(Valid), 64'd0);
        check("reset_regwrite", 64'(RegWrite), 64'd0);
        check("reset_busa", BusA, 64'h0);
        check("reset_busb", BusB, 64'h0);
        check("reset_store", StoreData, 64'h0);
        check("reset_aluctrl", 64'(ALUCtrl), 64'd0);
        check("reset_rd", 64'(Rd), 64'd0);
        idle_inputs();

        // Table-driven vectors: inputs and forward sources held across capture edge and check
        for (int i = 0; i < 7; i++) begin
            InRn = vecs[i].rn; InRm = vecs[i].rm; InRd = vecs[i].rd;
            InBusA = vecs[i].bus_a; InBusB = vecs[i].bus_b; InImm = vecs[i].imm;
            InALUSrc = vecs[i].alu_src; InALUCtrl = vecs[i].ctrl; InValid = vecs[i].valid;
            InRegWrite = vecs[i].rw; InMemRead = vecs[i].mr; InMemWrite = vecs[i].mw;
            ExMemRegWrite = vecs[i].ex_we; ExMemRd = vecs[i].ex_rd; ExMemResult = vecs[i].ex_res;
            MemWbRegWrite = vecs[i].wb_we; MemWbRd = vecs[i].wb_rd; MemWbData = vecs[i].wb_data;
            @(posedge Clk);
            @(negedge Clk);
            $display("[TB] vec %0d: BusA=%h BusB=%h StoreData=%h Valid=%0b Rd=%0d", i, BusA, BusB, StoreData, Valid, Rd);
            check($sformatf("vec%0d_busa", i), BusA, vecs[i].exp_a);
            check($sformatf("vec%0d_busb", i), BusB, vecs[i].exp_b);
            check($sformatf("vec%0d_store", i), StoreData, vecs[i].exp_s);
            check($sformatf("vec%0d_valid", i), 64'(Valid), 64'(vecs[i].valid));
            check($sformatf("vec%0d_aluctrl", i), 64'(ALUCtrl), 64'(vecs[i].ctrl));
            check($sformatf("vec%0d_rd", i), 64'(Rd), 64'(vecs[i].rd));
            check($sformatf("vec%0d_regwrite", i), 64'(RegWrite), 64'(vecs[i].rw));
            check($sformatf("vec%0d_memread", i), 64'(MemRead), 64'(vecs[i].mr));
            check($sformatf("vec%0d_memwrite", i), 64'(MemWrite), 64'(vecs[i].mw));
        end
        idle_inputs();

        // Write-through at capture: MEM/WB result survives after writeback leaves
        capture(5'd7, 5'd8, 5'd14, 64'h1, 64'h2, 1'b1, 1'b0);
        MemWbRegWrite = 1; MemWbRd = 5'd7; MemWbData = 64'hC0DE;
        @(posedge Clk);
        @(negedge Clk);
        MemWbRegWrite = 0; MemWbData = 64'h0;
        #1;
        $display("[TB] write-through: BusA=%h StoreData=%h", BusA, StoreData);
        check("wt_busa", BusA, 64'hC0DE);
        check("wt_store", StoreData, 64'h2);

        // Stall refresh: Rm=4 held while X4 is written back for one cycle
        @(negedge Clk);
        idle_inputs();
        capture(5'd1, 5'd4, 5'd15, 64'h3, 64'h1, 1'b1, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        Stall = 1;
        capture(5'd9, 5'd10, 5'd20, 64'hF0, 64'hF1, 1'b0, 1'b0);
        MemWbRegWrite = 1; MemWbRd = 5'd4; MemWbData = 64'h99;
        @(posedge Clk);
        @(negedge Clk);
        MemWbRegWrite = 0; MemWbData = 64'h0;
        @(posedge Clk);
        @(negedge Clk);
        Stall = 0;
        InValid = 0;
        #1;
        $display("[TB] stall refresh: BusB=%h StoreData=%h Valid=%0b Rd=%0d", BusB, StoreData, Valid, Rd);
        check("stall_busb", BusB, 64'h99);
        check("stall_store", StoreData, 64'h99);
        check("stall_busa", BusA, 64'h3);
        check("stall_valid", 64'(Valid), 64'd1);
        check("stall_rd", 64'(Rd), 64'd15);
        check("stall_memwrite", 64'(MemWrite), 64'd1);

        // Flush together with Stall discards the held instruction
        idle_inputs();
        capture(5'd2, 5'd3, 5'd16, 64'h5, 64'h6, 1'b1, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        Stall = 1; Flush = 1;
        @(posedge Clk);
        @(negedge Clk);
        $display("[TB] flush+stall: Valid=%0b RegWrite=%0b MemWrite=%0b", Valid, RegWrite, MemWrite);
        check("flush_valid", 64'(Valid), 64'd0);
        check("flush_regwrite", 64'(RegWrite), 64'd0);
        check("flush_memwrite", 64'(MemWrite), 64'd0);
        check("flush_busa", BusA, 64'h0);

        // Reset mid-stall: bubble, no refresh of the held operand
        idle_inputs();
        capture(5'd2, 5'd4, 5'd17, 64'h5, 64'h6, 1'b1, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Stall = 1; Reset = 1;
        MemWbRegWrite = 1; MemWbRd = 5'd4; MemWbData = 64'h77;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 0; MemWbRegWrite = 0; MemWbData = 64'h0;
        #1;
        $display("[TB] reset mid-stall: Valid=%0b BusB=%h Rd=%0d", Valid, BusB, Rd);
        check("rststall_valid", 64'(Valid), 64'd0);
        check("rststall_busb", BusB, 64'h0);
        check("rststall_rd", 64'(Rd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Pipeline register and operand-forwarding stage directly upstream of the 64-bit ALU. It captures decoded operands and control from the decode/register-read stage and resolves read-after-write hazards against the EX/MEM and MEM/WB stages. It presents final BusA/BusB operands, ALU control and downstream control to the ALU and the rest of the execute stage. It supports stall (hold) and flush (bubble insertion) from the hazard/branch logic.

## Interface
- DATA_WIDTH, 64, operand/result width
- ZERO_REG, 31, register number of XZR; never forwarded, always reads 0
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Stall  in  1  hold current contents (no capture)
- Flush  in  1  load a bubble on next edge
- InValid  in  1  decode slot holds a real instruction
- InRn, InRm, InRd  in  5 each  source A, source B/store register, destination register numbers
- InBusA, InBusB  in  DATA_WIDTH  register-file read data for Rn, Rm
- InImm  in  DATA_WIDTH  sign/zero-extended immediate
- InALUSrc  in  1  1: ALU B operand = immediate; 0: = Rm value
- InALUCtrl  in  4  ALU opcode (AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111)
- InRegWrite, InMemRead, InMemWrite  in  1 each  downstream control
- ExMemRegWrite  in  1; ExMemRd  in  5; ExMemResult  in  DATA_WIDTH  EX/MEM forwarding source
- MemWbRegWrite  in  1; MemWbRd  in  5; MemWbData  in  DATA_WIDTH  MEM/WB forwarding source (same values drive the register-file write port)
- Valid  out  1  stage holds a real instruction
- BusA, BusB  out  DATA_WIDTH  final ALU operands
- StoreData  out  DATA_WIDTH  forwarded Rm value for stores
- ALUCtrl  out  4; Rd  out  5; RegWrite, MemRead, MemWrite  out  1 each

## Operation
- Registered fields: Valid, Rn, Rm, Rd, RawA, RawB, Imm, ALUSrc, ALUCtrl, RegWrite, MemRead, MemWrite.
- Edge priority: Reset > Flush > Stall > capture.
- Reset and Flush both load: all fields 0, ALUCtrl 4'b0000. A bubble therefore has RegWrite = MemRead = MemWrite = 0.
- Capture (no Stall/Flush/Reset): latch all In* fields.
  - Write-through at capture: if MemWbRegWrite, MemWbRd == InRn and InRn != ZERO_REG, RawA <= MemWbData, else InBusA. RawB is handled the same way against InRm/InBusB.
  - If InRn == ZERO_REG, RawA <= 0; same for RawB/InRm.
- Stall: all fields hold, except for a held-operand refresh. If MemWbRegWrite, MemWbRd == Rn and Rn != ZERO_REG, RawA <= MemWbData (same for RawB/Rm). This preserves a result whose producer leaves writeback during the stall.
- Forwarding, combinational on outputs, applied to A from Rn and to B-source from Rm:
  - FwdA = ExMemResult if ExMemRegWrite and ExMemRd == Rn and Rn != ZERO_REG.
  - Otherwise FwdA = MemWbData if MemWbRegWrite and MemWbRd == Rn and Rn != ZERO_REG.
  - Otherwise FwdA = RawA.
  - EX/MEM has priority over MEM/WB (youngest producer wins).
- BusA = FwdA. StoreData = FwdB. BusB = Imm if ALUSrc, else FwdB.
- Forwarding is evaluated regardless of Valid; bubbles carry Rn = Rm = 0 and no control effects.
- Load-use hazards are excluded by the upstream hazard unit via Stall/Flush; this block does not detect them.

## Timing
- Latency: 1 cycle; In* captured at edge N appears on outputs after edge N.
- Forwarding path is purely combinational from ExMem*/MemWb* inputs to BusA/BusB/StoreData within the same cycle.
- Reset values: Valid 0, BusA/BusB/StoreData 0 (forward inputs idle), ALUCtrl 0000, Rd 0, RegWrite/MemRead/MemWrite 0.
- Stall held for k cycles: outputs hold, except operands that change through forwarding/refresh.
- Flush with Stall in the same cycle: bubble loaded; the held instruction is discarded.
- Reset mid-stall: bubble after the edge; no refresh applied.

## Test plan
- Reset: assert Reset with nonzero In* -> after edge, Valid=0, RegWrite=0, BusA=BusB=0, ALUCtrl=0000.
- Capture/imm: InRn=1, InBusA=5, InImm=0x10, ALUSrc=1, ALUCtrl=0010, no forwarding -> next cycle BusA=5, BusB=0x10, Valid=1.
- Forward priority: Rn=3 held; ExMemRd=3/Result=0xAA and MemWbRd=3/Data=0xBB, both RegWrite=1 -> BusA=0xAA; drop ExMemRegWrite -> BusA=0xBB.
- XZR: Rn=31, InBusA=0x55, ExMemRd=31, ExMemRegWrite=1, Result=0x77 -> BusA=0.
- Stall refresh: Rm=4 captured with RawB=1, ALUSrc=0; Stall=1 while MemWb writes X4=0x99 for one cycle, then inactive -> BusB=StoreData=0x99 remains after release.
- Flush+Stall together with Valid=1 held -> next cycle Valid=0, RegWrite=0, MemWrite=0.
